// File: rtl/aes_ahb_slave.sv
// aes_ahb_slave: AHB-Lite slave front end of the AES accelerator.
// Decodes 32-bit CPU transfers into a 128-bit input block buffer plus control
// strobes for the AES controller, and buffers one 128-bit result for read-back.
// Ports:
//   clk, n_rst                    clock, asynchronous active-low reset
//   hsel/haddr/htrans/hwrite/hsize/hwdata -> hrdata/hready/hresp   AHB-Lite slave
//   start, data_received, data_type, enc_dec                       controller strobes
//   fetch, done_chg_key           controller consumes block / key schedule done
//   block_out                     input block, word0 in [127:96]
//   result_valid, result_in -> result_ready                        result capture
// Optional build macro: AES_AHB_BYTESWAP_EN byte-reverses every 32-bit word on
// entry to DATA_IN and on exit from DATA_OUT (little-endian CPU byte order).
module aes_ahb_slave (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         hsel,
    input  logic [7:0]   haddr,
    input  logic [1:0]   htrans,
    input  logic         hwrite,
    input  logic [2:0]   hsize,
    input  logic [31:0]  hwdata,
    output logic [31:0]  hrdata,
    output logic         hready,
    output logic         hresp,
    output logic         start,
    output logic         data_received,
    output logic         data_type,
    output logic         enc_dec,
    input  logic         fetch,
    input  logic         done_chg_key,
    output logic [127:0] block_out,
    input  logic         result_valid,
    input  logic [127:0] result_in,
    output logic         result_ready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BLK_W  = 128;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t             state_q;
    logic               hready_q, hresp_q;
    logic [7:0]         addr_q,     addr_d;
    logic               write_q,    write_d;
    logic [DATA_W-1:0]  hrdata_q,   hrdata_d;
    logic               start_q,    start_d;
    logic               dtype_q,    dtype_d;
    logic               encdec_q,   encdec_d;
    logic               key_done_q, key_done_d;
    logic               in_full_q,  in_full_d;
    logic               out_valid_q, out_valid_d;
    logic               rdy_q,      rdy_d;
    logic [BLK_W-1:0]   in_buf_q,   in_buf_d;
    logic [BLK_W-1:0]   out_buf_q,  out_buf_d;

    logic acc_c, legal_c, din_wr_c, is_din_c, is_dout_c;
    logic wr_ctrl_c, wr_din_c, rd_stat_c, rd_dout3_c, capture_c;
    logic unused_htrans;

    // SEQ/NONSEQ are treated alike; only htrans[1] matters.
    assign unused_htrans = htrans[0];

    function automatic logic [31:0] bswap(input logic [31:0] w);
`ifdef AES_AHB_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Address-phase decode of the transfer currently on the bus.
    always_comb begin
        acc_c     = hsel & htrans[1] & hready_q;
        is_din_c  = (haddr[7:4] == 4'h1) && (haddr[1:0] == 2'b00);
        is_dout_c = (haddr[7:4] == 4'h2) && (haddr[1:0] == 2'b00);
        din_wr_c  = is_din_c & hwrite;
        legal_c   = (hsize == 3'b010) &&
                    ((haddr == 8'h00) ||
                     ((haddr == 8'h04) && !hwrite) ||
                     din_wr_c ||
                     (is_dout_c && !hwrite));
    end

    // Data-phase completion strobes; only legal transfers ever reach S_DATA.
    always_comb begin
        wr_ctrl_c  = (state_q == S_DATA) &&  write_q && (addr_q == 8'h00);
        wr_din_c   = (state_q == S_DATA) &&  write_q && (addr_q[7:4] == 4'h1);
        rd_stat_c  = (state_q == S_DATA) && !write_q && (addr_q == 8'h04);
        rd_dout3_c = (state_q == S_DATA) && !write_q && (addr_q == 8'h2C);
        capture_c  = result_valid & rdy_q;
    end

    // Next-state for registers, buffers and flags.
    always_comb begin
        addr_d      = addr_q;
        write_d     = write_q;
        dtype_d     = dtype_q;
        encdec_d    = encdec_q;
        start_d     = 1'b0;
        in_buf_d    = in_buf_q;
        in_full_d   = in_full_q;
        key_done_d  = key_done_q;
        out_valid_d = out_valid_q;
        out_buf_d   = out_buf_q;
        hrdata_d    = '0;

        if (acc_c) begin
            addr_d  = haddr;
            write_d = hwrite;
        end

        if (wr_ctrl_c) begin
            start_d  = hwdata[0];
            dtype_d  = hwdata[1];
            encdec_d = hwdata[2];
        end

        if (wr_din_c) begin
            case (addr_q[3:2])
                2'd0:    in_buf_d[127:96] = bswap(hwdata);
                2'd1:    in_buf_d[95:64]  = bswap(hwdata);
                2'd2:    in_buf_d[63:32]  = bswap(hwdata);
                default: in_buf_d[31:0]   = bswap(hwdata);
            endcase
        end

        // Word3 write fills the buffer; fetch frees it only when full.
        if (wr_din_c && (addr_q[3:2] == 2'd3)) begin
            in_full_d = 1'b1;
        end else if (fetch && in_full_q) begin
            in_full_d = 1'b0;
        end

        // A key-done event in the same cycle as a STATUS read keeps the flag.
        if (done_chg_key) begin
            key_done_d = 1'b1;
        end else if (rd_stat_c) begin
            key_done_d = 1'b0;
        end

        if (capture_c) begin
            out_valid_d = 1'b1;
            out_buf_d   = result_in;
        end else if (rd_dout3_c) begin
            out_valid_d = 1'b0;
        end

        // Read data is registered at address acceptance so it is valid for the
        // whole zero-wait data phase; it reflects updates landing on that edge.
        if (acc_c && legal_c && !hwrite) begin
            if (haddr == 8'h00) begin
                hrdata_d = {29'd0, encdec_d, dtype_d, 1'b0};
            end else if (haddr == 8'h04) begin
                hrdata_d = {28'd0, in_full_d | out_valid_d, in_full_d,
                            out_valid_d, key_done_d};
            end else if (out_valid_d) begin
                case (haddr[3:2])
                    2'd0:    hrdata_d = bswap(out_buf_d[127:96]);
                    2'd1:    hrdata_d = bswap(out_buf_d[95:64]);
                    2'd2:    hrdata_d = bswap(out_buf_d[63:32]);
                    default: hrdata_d = bswap(out_buf_d[31:0]);
                endcase
            end
        end

        rdy_d = !out_valid_d;
    end

    // Response FSM with registered hready/hresp for the upcoming data phase.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (acc_c && !legal_c) begin
                        state_q  <= S_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else if (acc_c && din_wr_c && in_full_d) begin
                        state_q  <= S_WAIT;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b0;
                    end else if (acc_c) begin
                        state_q  <= S_DATA;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end else begin
                        state_q  <= S_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // The fetch edge frees the buffer; the write completes next cycle.
                    if (fetch) begin
                        state_q  <= S_DATA;
                        hready_q <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state_q  <= S_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Register and buffer state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q      <= '0;
            write_q     <= 1'b0;
            hrdata_q    <= '0;
            start_q     <= 1'b0;
            dtype_q     <= 1'b0;
            encdec_q    <= 1'b0;
            key_done_q  <= 1'b0;
            in_full_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            in_buf_q    <= '0;
            out_buf_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            write_q     <= write_d;
            hrdata_q    <= hrdata_d;
            start_q     <= start_d;
            dtype_q     <= dtype_d;
            encdec_q    <= encdec_d;
            key_done_q  <= key_done_d;
            in_full_q   <= in_full_d;
            out_valid_q <= out_valid_d;
            rdy_q       <= rdy_d;
            in_buf_q    <= in_buf_d;
            out_buf_q   <= out_buf_d;
        end
    end

    assign hrdata        = hrdata_q;
    assign hready        = hready_q;
    assign hresp         = hresp_q;
    assign start         = start_q;
    assign data_received = in_full_q;
    assign data_type     = dtype_q;
    assign enc_dec       = encdec_q;
    assign block_out     = in_buf_q;
    assign result_ready  = rdy_q;

endmodule

// File: tb/tb_aes_ahb_slave.sv
// Testbench for aes_ahb_slave: directed scenarios plus randomized register
// traffic, checked against a transaction-level model through a scoreboard.
module tb_aes_ahb_slave;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         hsel = 1'b0;
    logic [7:0]   haddr = '0;
    logic [1:0]   htrans = '0;
    logic         hwrite = 1'b0;
    logic [2:0]   hsize = 3'b010;
    logic [31:0]  hwdata = '0;
    logic [31:0]  hrdata;
    logic         hready, hresp, start, data_received, data_type, enc_dec;
    logic         fetch = 1'b0;
    logic         done_chg_key = 1'b0;
    logic [127:0] block_out;
    logic         result_valid = 1'b0;
    logic [127:0] result_in = '0;
    logic         result_ready;

    aes_ahb_slave dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .start(start),
        .data_received(data_received), .data_type(data_type), .enc_dec(enc_dec),
        .fetch(fetch), .done_chg_key(done_chg_key), .block_out(block_out),
        .result_valid(result_valid), .result_in(result_in),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          waits;   // -1 = any number of wait states
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Transaction-level model of the programmer-visible state.
    bit          m_dt, m_ed, m_kd, m_full, m_ov, m_start;
    logic [31:0] m_in[4];
    logic [31:0] m_out[4];

    function automatic logic [31:0] swp(input logic [31:0] w);
`ifdef AES_AHB_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_dt = 0; m_ed = 0; m_kd = 0; m_full = 0; m_ov = 0; m_start = 0;
        for (int i = 0; i < 4; i++) begin
            m_in[i] = '0;
            m_out[i] = '0;
        end
    endfunction

    function automatic exp_t model_xfer(input bit wr, input logic [7:0] a,
                                        input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        int   idx;
        bit   is_din, is_dout, legal;
        e = '{err: 1'b0, rd: !wr, data: 32'd0, waits: 0};
        idx = (int'(a) % 16) / 4;
        is_din  = (a >= 8'h10) && (a <= 8'h1C) && (a % 4 == 0);
        is_dout = (a >= 8'h20) && (a <= 8'h2C) && (a % 4 == 0);
        legal = (sz == 3'b010) && ((a == 8'h00) || (a == 8'h04 && !wr) ||
                                   (is_din && wr) || (is_dout && !wr));
        if (!legal) begin
            e.err = 1'b1; e.rd = 1'b0; e.waits = 1;
            return e;
        end
        if (wr) begin
            if (a == 8'h00) begin
                m_start = wd[0]; m_dt = wd[1]; m_ed = wd[2];
            end else begin
                m_in[idx] = swp(wd);
                if (idx == 3) m_full = 1;
            end
        end else if (a == 8'h00) begin
            e.data = {29'd0, m_ed, m_dt, 1'b0};
        end else if (a == 8'h04) begin
            e.data = {28'd0, m_full | m_ov, m_full, m_ov, m_kd};
            m_kd = 0;
        end else begin
            e.data = m_ov ? swp(m_out[idx]) : 32'd0;
            if (idx == 3) m_ov = 0;
        end
        return e;
    endfunction

    // One non-pipelined AHB transfer; the expected response goes to the scoreboard.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int ew = 0);
        exp_t e;
        int   n;
        e = model_xfer(wr, a, sz, wd);
        if (ew < 0) e.waits = -1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (hready) break;
            n++;
            if (n > 30) begin
                check("xfer_timeout", 128'(n), 128'(0));
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic check_side();
        #1;
        check("data_received", 128'(data_received), 128'(m_full));
        check("result_ready", 128'(result_ready), 128'(!m_ov));
        check("block_out", block_out, {m_in[0], m_in[1], m_in[2], m_in[3]});
        check("data_type", 128'(data_type), 128'(m_dt));
        check("enc_dec", 128'(enc_dec), 128'(m_ed));
        check("start", 128'(start), 128'(m_start));
        m_start = 0;
    endtask

    task automatic pulse_fetch();
        @(posedge clk); #1 fetch = 1'b1;
        @(posedge clk); #1 fetch = 1'b0;
        m_full = 0;
    endtask

    task automatic pulse_result(input logic [127:0] d);
        @(posedge clk); #1 result_valid = 1'b1; result_in = d;
        @(posedge clk); #1 result_valid = 1'b0;
        if (!m_ov) begin
            m_ov = 1;
            for (int i = 0; i < 4; i++) m_out[i] = d[127 - 32*i -: 32];
        end
    endtask

    task automatic pulse_key();
        @(posedge clk); #1 done_chg_key = 1'b1;
        @(posedge clk); #1 done_chg_key = 1'b0;
        m_kd = 1;
    endtask

    // Monitor: tracks data phases on the bus and checks each completed one.
    initial begin
        bit   in_data;
        int   waits;
        exp_t e;
        in_data = 0;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                in_data = 0;
            end else if (in_data && !hready) begin
                waits++;
            end else begin
                if (in_data) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected", 128'(1), 128'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("hresp", 128'(hresp), 128'(e.err));
                        if (e.waits >= 0) check("wait_states", 128'(waits), 128'(e.waits));
                        if (e.rd && !e.err) check("hrdata", 128'(hrdata), 128'(e.data));
                    end
                end
                in_data = hsel && htrans[1] && hready;
                waits = 0;
            end
        end
    end

    initial begin
        logic [31:0]  rnd;
        logic [7:0]   a;
        logic [127:0] blk;
        int           n;
        model_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hready", 128'(hready), 128'(1));
        check("rst_hresp", 128'(hresp), 128'(0));
        check("rst_hrdata", 128'(hrdata), 128'(0));
        check("rst_result_ready", 128'(result_ready), 128'(1));
        check("rst_block_out", block_out, 128'(0));
        @(posedge clk); #1 n_rst = 1'b1;
        check_side();
        xfer(0, 8'h04, 3'b010, 32'd0);

        // CTRL write with START: one-cycle pulse, DATA_TYPE set.
        xfer(1, 8'h00, 3'b010, 32'h3);
        check_side();
        @(posedge clk); #1;
        check("start_one_cycle", 128'(start), 128'(0));
        xfer(0, 8'h00, 3'b010, 32'd0);

        // Fill the input block, then fetch it.
        xfer(1, 8'h10, 3'b010, 32'h00112233);
        xfer(1, 8'h14, 3'b010, 32'h44556677);
        xfer(1, 8'h18, 3'b010, 32'h8899AABB);
        check_side();
        xfer(1, 8'h1C, 3'b010, 32'hCCDDEEFF);
        check_side();
`ifndef AES_AHB_BYTESWAP_EN
        check("block_literal", block_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
        xfer(0, 8'h04, 3'b010, 32'd0);
        pulse_fetch();
        check_side();

        // Refill, then a DATA_IN write while full stalls until the cycle after fetch.
        xfer(1, 8'h1C, 3'b010, 32'h0BADF00D);
        check_side();
        m_full = 0;
        fork
            xfer(1, 8'h10, 3'b010, 32'hA5A55A5A, -1);
            begin
                repeat (4) @(posedge clk);
                #1 fetch = 1'b1;
                @(negedge clk);
                check("stall_at_fetch", 128'(hready), 128'(0));
                @(posedge clk); #1 fetch = 1'b0;
                @(negedge clk);
                check("release_after_fetch", 128'(hready), 128'(1));
            end
        join
        check_side();

        // Result capture and read-back.
        pulse_result(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        check_side();
        xfer(0, 8'h04, 3'b010, 32'd0);
        for (int i = 0; i < 4; i++) xfer(0, 8'(8'h20 + 4*i), 3'b010, 32'd0);
        check_side();
        xfer(0, 8'h24, 3'b010, 32'd0);

        // KEY_DONE: sticky, cleared by a read unless set again in that cycle.
        pulse_key();
        @(posedge clk); #1 done_chg_key = 1'b1;
        xfer(0, 8'h04, 3'b010, 32'd0);
        #1 done_chg_key = 1'b0;
        m_kd = 1;
        xfer(0, 8'h04, 3'b010, 32'd0);
        xfer(0, 8'h04, 3'b010, 32'd0);

        // Error responses leave all state unchanged.
        xfer(1, 8'h00, 3'b000, 32'h7);
        check_side();
        xfer(1, 8'h24, 3'b010, 32'h1234);
        xfer(0, 8'h04, 3'b010, 32'd0);

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            rnd = $urandom;
            case ($urandom_range(0, 9))
                0: xfer(1, 8'h00, 3'b010, rnd);
                1: xfer(0, 8'h00, 3'b010, 32'd0);
                2: xfer(0, 8'h04, 3'b010, 32'd0);
                3, 4: begin
                    if (m_full) pulse_fetch();
                    xfer(1, 8'(8'h10 + 4*$urandom_range(0, 3)), 3'b010, rnd);
                end
                5: xfer(0, 8'(8'h20 + 4*$urandom_range(0, 3)), 3'b010, 32'd0);
                6: begin
                    case ($urandom_range(0, 6))
                        0: a = 8'h00;
                        1: a = 8'h04;
                        2: a = 8'h28;
                        3: a = 8'h14;
                        4: a = 8'h08;
                        5: a = 8'h30;
                        default: a = 8'h12;
                    endcase
                    if (a == 8'h00) xfer(1, a, 3'b001, rnd);
                    else xfer(a == 8'h04 || a == 8'h28, a, 3'b010, rnd);
                end
                7: pulse_fetch();
                8: begin
                    blk = {$urandom, $urandom, $urandom, $urandom};
                    pulse_result(blk);
                end
                default: pulse_key();
            endcase
            check_side();
        end

        // Reset in the middle of a DATA_IN data phase.
        if (m_full) pulse_fetch();
        xfer(1, 8'h10, 3'b010, 32'h11111111);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 8'h14; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h22222222;
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("midrst_hready", 128'(hready), 128'(1));
        check("midrst_hresp", 128'(hresp), 128'(0));
        check("midrst_block", block_out, 128'(0));
        sb_q.delete();
        @(posedge clk); #1 n_rst = 1'b1;
        model_reset();
        check_side();
        xfer(0, 8'h04, 3'b010, 32'd0);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("sb_drain", 128'(sb_q.size()), 128'(0));
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
